// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths, state enum and pointer helper for the FIFO family
package fifo_pkg;
  localparam int WIDTH = 32;
  localparam int LEN_W = 8;
  typedef enum logic {IDLE, READ} state_e;
  function automatic logic [1:0] inc3(input logic [1:0] p);
    return p == 2'd2 ? 2'd0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if: FIFO read port plus valid/ready stream of the burst reader
interface fifo_burst_reader_if #(parameter int W = fifo_pkg::WIDTH) ();
  logic         fifo_rn;
  logic         fifo_empty;
  logic [W-1:0] fifo_dout;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  modport master (output fifo_rn, m_data, m_valid, input fifo_empty, fifo_dout, m_ready);
  modport slave  (input fifo_rn, m_data, m_valid, output fifo_empty, fifo_dout, m_ready);
endinterface

// File: rtl/skid_buf3.sv
// skid_buf3: 3-entry circular buffer absorbing FIFO read latency and back-pressure
module skid_buf3 import fifo_pkg::*; #(
  parameter int W = fifo_pkg::WIDTH
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [0:2];
  logic [1:0]   hd_q, tl_q, cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
      hd_q  <= '0;
      tl_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      hd_q  <= '0;
      tl_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[tl_q] <= din_i;
        tl_q        <= inc3(tl_q);
      end
      if (pop_i) hd_q <= inc3(hd_q);
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end
  assign head_o  = mem_q[hd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops len words from the FIFO and streams them out via valid/ready
module fifo_burst_reader import fifo_pkg::*; #(
  parameter int WIDTH = fifo_pkg::WIDTH,
  parameter int LEN_W = fifo_pkg::LEN_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  fifo_burst_reader_if.master bus,
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  count_o
);
  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, iss_q, iss_d, cnt_q, cnt_d;
  logic             infl_q, done_q, done_d;
  logic [1:0]       buf_cnt;
  logic             rn, pop, clr;
  // read only while a slot is guaranteed for the word, so the buffer can never overflow
  assign rn  = state_q == READ && !bus.fifo_empty && iss_q < len_q &&
               ({1'b0, buf_cnt} + {2'b0, infl_q}) <= 3'd2;
  assign pop = bus.m_valid && bus.m_ready;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    iss_d   = iss_q + LEN_W'(rn);
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    if (state_q == IDLE && start_i) begin
      clr     = 1'b1;
      len_d   = len_i;
      iss_d   = '0;
      cnt_d   = '0;
      done_d  = len_i == '0;
      state_d = len_i == '0 ? IDLE : READ;
    end else if (pop) begin
      cnt_d   = cnt_q + 1'b1;
      done_d  = cnt_d == len_q;
      state_d = cnt_d == len_q ? IDLE : state_q;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      len_q   <= '0;
      iss_q   <= '0;
      cnt_q   <= '0;
      infl_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      iss_q   <= iss_d;
      cnt_q   <= cnt_d;
      infl_q  <= rn;
      done_q  <= done_d;
    end
  end
  skid_buf3 #(.W(WIDTH)) u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr),
    .push_i  (infl_q),
    .pop_i   (pop),
    .din_i   (bus.fifo_dout),
    .head_o  (bus.m_data),
    .count_o (buf_cnt)
  );
  assign bus.fifo_rn = rn;
  assign bus.m_valid = buf_cnt != 2'd0;
  assign busy_o      = state_q == READ;
  assign done_o      = done_q;
  assign count_o     = cnt_q;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed bursts checked against a queue-level model every cycle
module tb_fifo_burst_reader;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0]  len = '0;
  logic        busy, done;
  logic [7:0]  count;
  int          n_chk = 0, n_err = 0;
  logic [31:0] mem [256];
  logic [7:0]  wr_ptr = '0, rd_ptr = '0;
  logic [31:0] got [$];
  fifo_burst_reader_if bus ();
  fifo_burst_reader dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .len_i   (len),
    .bus     (bus),
    .busy_o  (busy),
    .done_o  (done),
    .count_o (count)
  );
  always #5 clk = ~clk;
  // FIFO environment: one-cycle read latency
  assign bus.fifo_empty = rd_ptr == wr_ptr;
  always @(posedge clk) begin
    if (bus.fifo_rn && !bus.fifo_empty) begin
      bus.fifo_dout <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 8'd1;
    end
  end
  // model: occupancy = words issued minus words delivered
  int         e_iss, e_cnt, e_len;
  logic       e_busy, e_done, e_infl, e_rn, e_valid;
  logic [7:0] e_base;
  assign e_rn    = e_busy && !bus.fifo_empty && e_iss < e_len && (e_iss - e_cnt) <= 2;
  assign e_valid = e_busy && (e_iss - e_cnt - int'(e_infl)) > 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_iss <= 0; e_cnt <= 0; e_len <= 0; e_busy <= 0; e_done <= 0; e_infl <= 0; e_base <= 0;
    end else begin
      e_done <= 1'b0;
      if (!e_busy && start) begin
        e_iss <= 0; e_cnt <= 0; e_infl <= 0; e_base <= rd_ptr; e_len <= int'(len);
        e_busy <= len != 0;
        e_done <= len == 0;
      end else if (e_busy) begin
        e_iss  <= e_iss + int'(e_rn);
        e_infl <= e_rn;
        if (e_valid && bus.m_ready) begin
          e_cnt <= e_cnt + 1;
          if (e_cnt + 1 == e_len) begin
            e_busy <= 1'b0;
            e_done <= 1'b1;
          end
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("busy", {31'b0, busy}, {31'b0, e_busy});
    chk("done", {31'b0, done}, {31'b0, e_done});
    chk("count", {24'b0, count}, e_cnt);
    chk("fifo_rn", {31'b0, bus.fifo_rn}, {31'b0, e_rn});
    chk("m_valid", {31'b0, bus.m_valid}, {31'b0, e_valid});
    if (e_valid) chk("m_data", bus.m_data, mem[8'(int'(e_base) + e_cnt)]);
    if (rst_n && bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
  end
  task automatic push(input logic [31:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 8'd1;
  endtask
  task automatic do_start(input logic [7:0] l);
    @(posedge clk); #2;
    start = 1'b1; len = l;
    @(posedge clk); #2;
    start = 1'b0; len = 8'hAA;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    if (!done) chk("done_timeout", {31'b0, done}, 32'd1);
  endtask
  task automatic chk_got(input string nm, input logic [31:0] first, input int num);
    chk({nm, "_n"}, got.size(), num);
    for (int i = 0; i < num && i < got.size(); i++) chk(nm, got[i], first + i);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n;
    logic [7:0] rp;
    bus.m_ready = 1'b1;
    repeat (2) @(posedge clk); #2;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, bus.m_valid}, 32'd0);
    chk("rst_data", bus.m_data, 32'd0);
    rst_n = 1'b1;
    // basic burst
    push(100); push(150); got.delete();
    do_start(2); wait_done(n);
    chk("basic_lat", n, 5);
    chk("basic_cnt", {24'b0, count}, 32'd2);
    chk("basic_empty", {31'b0, bus.fifo_empty}, 32'd1);
    chk("basic_n", got.size(), 2);
    if (got.size() == 2) begin
      chk("basic_d0", got[0], 32'd100);
      chk("basic_d1", got[1], 32'd150);
    end
    // back-pressure
    for (int i = 1; i <= 8; i++) push(i);
    got.delete();
    do_start(8);
    fork
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #2;
        bus.m_ready = ((i / 2) % 2) == 1;
      end
      wait_done(n);
    join
    bus.m_ready = 1'b1;
    chk_got("bp_data", 32'd1, 8);
    chk("bp_cnt", {24'b0, count}, 32'd8);
    // underrun
    push(21); push(22); got.delete();
    do_start(4);
    fork
      begin
        repeat (10) @(posedge clk);
        #2; push(23); push(24);
      end
      wait_done(n);
    join
    chk("ur_lat", n, 15);
    chk_got("ur_data", 32'd21, 4);
    // zero length
    rp = rd_ptr;
    do_start(0); wait_done(n);
    chk("zl_lat", n, 1);
    chk("zl_cnt", {24'b0, count}, 32'd0);
    chk("zl_noread", {24'b0, rd_ptr}, {24'b0, rp});
    // start during a burst is ignored
    push(31); push(32); push(33); got.delete();
    do_start(3);
    @(posedge clk); #2; start = 1'b1; len = 8'd7;
    @(posedge clk); #2; start = 1'b0;
    wait_done(n);
    chk("ign_lat", n, 4);
    chk("ign_cnt", {24'b0, count}, 32'd3);
    chk_got("ign_data", 32'd31, 3);
    // reset mid-burst
    for (int i = 41; i <= 45; i++) push(i);
    got.delete();
    do_start(5);
    n = 0;
    while (got.size() < 2 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("mid_hs", got.size(), 2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_busy", {31'b0, busy}, 32'd0);
    chk("mid_done", {31'b0, done}, 32'd0);
    chk("mid_count", {24'b0, count}, 32'd0);
    chk("mid_rn", {31'b0, bus.fifo_rn}, 32'd0);
    chk("mid_valid", {31'b0, bus.m_valid}, 32'd0);
    chk("mid_data", bus.m_data, 32'd0);
    repeat (2) @(posedge clk); #2;
    rst_n = 1'b1;
    push(46); push(47); got.delete();
    do_start(3); wait_done(n);
    chk_got("mid_data", 32'd45, 3);
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
